// File: rtl/console_bus_sequencer_if.sv
// CPU-socket / buffered-peripheral bus signals between the E/Q sequencer
// and the rest of the console.
interface console_bus_if;
  // Handshake: a selected cycle holds in Q3 while dev_rdy = 0. The clk in
  // which dev_rdy = 1 (or the wait limit is reached) is the last one of
  // the cycle. dev_rdy is ignored in unselected cycles.
  logic cpu_rw;
  logic dev_sel;
  logic dev_rdy;
  logic e;
  logic q;
  logic xcvr_oe_n;
  logic xcvr_t_nr;
  logic dev_wr_strobe;
  logic timeout;

  modport master (
    input  cpu_rw, dev_sel, dev_rdy,
    output e, q, xcvr_oe_n, xcvr_t_nr, dev_wr_strobe, timeout
  );

  modport slave (
    output cpu_rw, dev_sel, dev_rdy,
    input  e, q, xcvr_oe_n, xcvr_t_nr, dev_wr_strobe, timeout
  );
endinterface

// File: rtl/console_bus_sequencer.sv
// 6809E E/Q quadrature generator with data-bus transceiver sequencing
// and bounded E-high stretching for slow peripherals.
module console_bus_sequencer #(
  parameter int unsigned MAX_WAIT = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  console_bus_if.master        bus,
  output logic [1:0]           dbg_phase
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {Q0 = 2'd0, Q1 = 2'd1, Q2 = 2'd2, Q3 = 2'd3} phase_t;

  phase_t          state, state_nxt;
  logic [CW-1:0]   wait_cnt, wait_cnt_nxt;
  logic            cyc_rw, cyc_sel;
  logic            stretch, at_limit, last_q3;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    stretch      = cyc_sel && !bus.dev_rdy;
    at_limit     = (wait_cnt == CW'(MAX_WAIT));
    case (state)
      Q0: state_nxt = Q1;
      Q1: state_nxt = Q2;
      Q2: state_nxt = Q3;
      Q3: begin
        if (!stretch || at_limit) begin
          state_nxt = Q0;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: state_nxt = Q0;
    endcase
    last_q3 = (state == Q3) && (state_nxt == Q0);
  end

  // Both pulses are combinational so they line up with the exit clk even
  // when dev_rdy rises in that same clk.
  assign bus.dev_wr_strobe = last_q3 && cyc_sel && !cyc_rw;
  assign bus.timeout       = last_q3 && stretch && at_limit;
  assign dbg_phase         = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= Q0;
      wait_cnt      <= '0;
      bus.e         <= 1'b0;
      bus.q         <= 1'b0;
      bus.xcvr_oe_n <= 1'b1;
      bus.xcvr_t_nr <= 1'b0;
      cyc_sel       <= 1'b0;
      cyc_rw        <= 1'b1;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state_nxt == Q0) ? '0 : wait_cnt_nxt;
      bus.e    <= (state_nxt == Q2) || (state_nxt == Q3);
      bus.q    <= (state_nxt == Q1) || (state_nxt == Q2);
      // Direction only moves here, a full clk before the enable edge.
      if (state == Q1) begin
        cyc_rw  <= bus.cpu_rw;
        cyc_sel <= bus.dev_sel;
        if (bus.dev_sel) bus.xcvr_t_nr <= ~bus.cpu_rw;
      end
      if (state == Q2) bus.xcvr_oe_n <= ~cyc_sel;
      if (last_q3)     bus.xcvr_oe_n <= 1'b1;
    end
  end
endmodule

// File: tb/tb_console_bus_sequencer.sv
// Directed bench for console_bus_sequencer; each step drives inputs at the
// falling edge and checks {e,q,oe_n,t_nr,strobe,timeout} 1 ns later.
module tb_console_bus_sequencer;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_phase;
  int         errors;
  int         checks;

  console_bus_if bus ();

  console_bus_sequencer #(.MAX_WAIT(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .dbg_phase (dbg_phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [5:0] obs();
    return {bus.e, bus.q, bus.xcvr_oe_n, bus.xcvr_t_nr, bus.dev_wr_strobe, bus.timeout};
  endfunction

  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] o;
    o = obs();
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s: observed e,q,oe_n,t_nr,strb,to=%b expected=%b", tag, o, exp);
    end
  endtask

  // One clk: drive inputs after the falling edge, then check that clk.
  task automatic step(input string tag, input logic rw, input logic sel,
                      input logic rdy, input logic [5:0] exp);
    @(negedge clk);
    bus.cpu_rw  = rw;
    bus.dev_sel = sel;
    bus.dev_rdy = rdy;
    #1;
    check(tag, exp);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    bus.cpu_rw  = 1'b1;
    bus.dev_sel = 1'b0;
    bus.dev_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset", 6'b001000);

    // Idle: unselected cycles, fixed 4-clk E/Q period.
    for (int i = 0; i < 3; i++) begin
      step("idle_q1", 1'b1, 1'b0, 1'b1, 6'b011000);
      step("idle_q2", 1'b1, 1'b0, 1'b1, 6'b111000);
      step("idle_q3", 1'b1, 1'b0, 1'b1, 6'b101000);
      step("idle_q0", 1'b1, 1'b0, 1'b1, 6'b001000);
    end

    // Selected read, peripheral ready.
    step("rd_q1", 1'b1, 1'b1, 1'b1, 6'b011000);
    step("rd_q2", 1'b0, 1'b0, 1'b1, 6'b111000);
    step("rd_q3", 1'b0, 1'b0, 1'b1, 6'b100000);
    step("rd_q0", 1'b1, 1'b0, 1'b1, 6'b001000);

    // Selected write, dev_rdy low for 3 stretch clks.
    step("wr_q1", 1'b0, 1'b1, 1'b1, 6'b011000);
    step("wr_q2", 1'b1, 1'b0, 1'b0, 6'b111100);
    step("wr_q3a", 1'b1, 1'b0, 1'b0, 6'b100100);
    step("wr_q3b", 1'b1, 1'b0, 1'b0, 6'b100100);
    step("wr_q3c", 1'b1, 1'b0, 1'b0, 6'b100100);
    step("wr_q3_end", 1'b1, 1'b0, 1'b1, 6'b100110);
    step("wr_q0", 1'b1, 1'b0, 1'b1, 6'b001100);

    // Write with dev_rdy stuck low: 8 Q3 clks, then forced exit.
    step("to_q1", 1'b0, 1'b1, 1'b0, 6'b011100);
    step("to_q2", 1'b0, 1'b1, 1'b0, 6'b111100);
    for (int i = 0; i < 7; i++) step("to_q3_wait", 1'b0, 1'b1, 1'b0, 6'b100100);
    step("to_q3_last", 1'b0, 1'b1, 1'b0, 6'b100111);
    step("to_q0", 1'b1, 1'b0, 1'b0, 6'b001100);
    step("after_to_q1", 1'b1, 1'b0, 1'b0, 6'b011100);
    step("after_to_q2", 1'b1, 1'b0, 1'b0, 6'b111100);
    step("after_to_q3", 1'b1, 1'b0, 1'b0, 6'b101100);
    step("after_to_q0", 1'b1, 1'b0, 1'b1, 6'b001100);

    // Read then write back-to-back: direction flips while disabled.
    step("b2b_rd_q1", 1'b1, 1'b1, 1'b1, 6'b011100);
    step("b2b_rd_q2", 1'b0, 1'b0, 1'b1, 6'b111000);
    step("b2b_rd_q3", 1'b0, 1'b0, 1'b1, 6'b100000);
    step("b2b_rd_q0", 1'b1, 1'b0, 1'b1, 6'b001000);
    step("b2b_wr_q1", 1'b0, 1'b1, 1'b1, 6'b011000);
    step("b2b_wr_q2", 1'b1, 1'b0, 1'b1, 6'b111100);
    step("b2b_wr_q3", 1'b1, 1'b0, 1'b1, 6'b100110);
    step("b2b_wr_q0", 1'b1, 1'b0, 1'b1, 6'b001100);

    // Reset on the 2nd stretch clk.
    step("rs_q1", 1'b0, 1'b1, 1'b0, 6'b011100);
    step("rs_q2", 1'b1, 1'b0, 1'b0, 6'b111100);
    step("rs_q3a", 1'b1, 1'b0, 1'b0, 6'b100100);
    step("rs_q3b", 1'b1, 1'b0, 1'b0, 6'b100100);
    #1;
    rst = 1'b1;
    #1;
    check("rs_async", 6'b001000);
    @(negedge clk);
    #1;
    check("rs_held", 6'b001000);
    rst = 1'b0;
    #1;
    check("rs_release", 6'b001000);
    step("rs_after_q1", 1'b1, 1'b0, 1'b1, 6'b011000);
    step("rs_after_q2", 1'b1, 1'b0, 1'b1, 6'b111000);
    step("rs_after_q3", 1'b1, 1'b0, 1'b1, 6'b101000);
    step("rs_after_q0", 1'b1, 1'b0, 1'b1, 6'b001000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed time limit reached, required bench completion");
    $fatal(1, "watchdog");
  end
endmodule
